adder_share_ctrl: RTL
=====================

Name: adder_share_ctrl

Overview:
- Scheduler that shares one external 16-bit ripple-carry adder between NUM_REQ requesters.
- Arbitrates requests round-robin, latches the winner's operands, and drives them onto the adder. Registers the adder's sum and overflow, then returns them to the winning requester over a valid/ready response handshake.
- Sits between requester blocks and a single adder_16bit instance. The adder itself is not inside this block.

Parameters:
- WIDTH, 16, operand/sum width; must match the attached adder.
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  NUM_REQ  one-hot result valid, to the granted requester.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_sum  out  WIDTH  registered sum, shared by all requesters.
- rsp_overflow  out  1  registered adder overflow (carry out of MSB).
- add_a  out  WIDTH  operand A to the adder.
- add_b  out  WIDTH  operand B to the adder.
- add_cin  out  1  carry-in to the adder.
- add_sum  in  WIDTH  sum from the adder (combinational path).
- add_overflow  in  1  overflow from the adder.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state = IDLE;
  - operand registers, rsp_sum and rsp_overflow = 0;
  - grant register = 0;
  - last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - Consequently all outputs are 0 in the cycle after reset: req_ready, rsp_valid, add_a, add_b, add_cin, busy.
- Reset mid-operation discards the in-flight operation. No rsp_valid is produced for it.
- FSM state IDLE:
  - Priority order is last_grant+1, last_grant+2, ... (mod NUM_REQ). Winner = first index in that order with req_valid high.
  - req_ready[winner] = 1, combinationally from req_valid. Requesters must not derive req_valid from req_ready.
  - On that edge: latch winner's a, b, cin into the operand registers; latch the winner index into grant; go to EXEC.
  - If no req_valid is high, stay in IDLE with req_ready = 0.
- FSM state EXEC (exactly 1 cycle):
  - add_a/add_b/add_cin carry the operand registers.
  - At the end of the cycle, capture add_sum into rsp_sum and add_overflow into rsp_overflow; go to RESP.
- FSM state RESP:
  - rsp_valid[grant] = 1; all other rsp_valid bits are 0.
  - rsp_sum and rsp_overflow are held stable.
  - When rsp_ready[grant] = 1: last_grant <= grant; go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Outside IDLE, req_ready is all zeros. New requests wait; a pending req_valid must be held until req_ready.
- add_a, add_b and add_cin always carry the operand registers. They stay stable from EXEC through RESP and keep their last value in IDLE.
- Latency: accept at edge T, then rsp_valid high during cycle T+2 (counting the IDLE accept cycle as T). Minimum 3 cycles per operation, including the return to IDLE.
- Arithmetic is performed entirely by the external adder; this block does no arithmetic.
  - Wrap-around: rsp_sum = (a+b+cin) mod 2^WIDTH.
  - Overflow: rsp_overflow = carry out of the MSB.
- Simultaneous requests: only the round-robin winner is accepted; the others remain pending. No requester is starved; worst-case wait is NUM_REQ-1 operations.
- rsp_ready asserted with no matching rsp_valid: no effect.

Test Plan:
1. Single request: after reset, req0 a=0x0001 b=0x0002 cin=0 → req_ready[0]=1 in the same cycle; busy=1 next cycle; 2 cycles after accept, rsp_valid=2'b01, rsp_sum=0x0003, rsp_overflow=0.
2. Wrap-around carry: req1 a=0xFFFF b=0x0001 cin=0 → rsp_valid=2'b10, rsp_sum=0x0000, rsp_overflow=1. Also req0 a=0x7FFF b=0x0000 cin=1 → rsp_sum=0x8000, rsp_overflow=0.
3. Round-robin: both req_valid held high continuously with distinct operands → grants alternate 0,1,0,1 across four operations. Each rsp_sum matches its own requester's operands; req_ready is never two-hot.
4. Backpressure: rsp_ready held 0 for 5 cycles in RESP → rsp_valid, rsp_sum, add_a/add_b stay constant; req_ready=0 and busy=1 throughout. Completion occurs one cycle after rsp_ready=1.
5. Reset mid-EXEC: assert rst during EXEC → next cycle all outputs 0 and no rsp_valid is produced. With both requesters then valid, requester 0 is granted first.
6. Stray ready: rsp_ready=2'b11 while idle, then rsp_ready[1]=1 only while the grant is 0 in RESP → no state change; completion only on rsp_ready[0].

Source files
------------

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin scheduler sharing one external adder between requesters
module adder_share_ctrl #(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ-1:0]         req_cin,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic                       rsp_overflow,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic                       add_cin,
   input  logic [WIDTH-1:0]           add_sum,
   input  logic                       add_overflow,
   output logic                       busy
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = GW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] op_a, op_b, sum_q;
   logic             op_cin, ovf_q;
   logic [GW-1:0]    grant, last_grant, win_idx;
   logic             win_found;
   logic [CW-1:0]    cand;

   // Scan from lowest to highest priority so the nearest requester after last_grant wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = CW'(last_grant) + CW'(k);
         if (cand >= CW'(NUM_REQ))
            cand = cand - CW'(NUM_REQ);
         if (req_valid[cand[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready[grant]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a       <= '0;
         op_b       <= '0;
         op_cin     <= 1'b0;
         sum_q      <= '0;
         ovf_q      <= 1'b0;
         grant      <= '0;
         last_grant <= GW'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_a   <= req_a[win_idx*WIDTH +: WIDTH];
                  op_b   <= req_b[win_idx*WIDTH +: WIDTH];
                  op_cin <= req_cin[win_idx];
                  grant  <= win_idx;
               end
            end
            EXEC: begin
               sum_q <= add_sum;
               ovf_q <= add_overflow;
            end
            RESP: begin
               if (rsp_ready[grant])
                  last_grant <= grant;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      if (state == IDLE && win_found)
         req_ready[win_idx] = 1'b1;
      if (state == RESP)
         rsp_valid[grant] = 1'b1;
   end

   assign add_a        = op_a;
   assign add_b        = op_b;
   assign add_cin      = op_cin;
   assign rsp_sum      = sum_q;
   assign rsp_overflow = ovf_q;
endmodule
